// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word handshake and status bundle between the UART receiver and its consumer.
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data_out;
  logic rx_data_valid;
  logic rx_data_ready;
  logic parity_err;
  logic frame_err;
  logic break_det;
  logic overrun_err;
  logic rx_busy;
  modport master (
    output rx_data_out, rx_data_valid, parity_err, frame_err, break_det, overrun_err, rx_busy,
    input  rx_data_ready
  );
  modport slave (
    input  rx_data_out, rx_data_valid, parity_err, frame_err, break_det, overrun_err, rx_busy,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority voting, parity/frame/break/overrun detection and valid/ready output.
module uart_rx_param #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rs232_rx,
  uart_rx_param_if.master dout
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;
  state_t state;
  logic s1, s2, rx_d;
  logic [DW-1:0] div_cnt;
  logic [OW-1:0] os_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic sa, sb, par, any_one, fe_acc, pe_acc;
  logic tick, eval, maj, brk, done, pending;
  assign tick    = div_cnt == DW'(DIV - 1);
  assign eval    = tick && os_cnt == OW'(OVERSAMPLE / 2 + 1);
  assign maj     = (sa & sb) | (sa & s2) | (sb & s2);
  assign brk     = ~any_one & ~maj;
  assign done    = state == STOP && eval && bit_cnt == BW'(STOP_BITS - 1);
  assign pending = dout.rx_data_valid & ~dout.rx_data_ready;
  assign dout.rx_busy = state != IDLE;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      s1                 <= 1'b1;
      s2                 <= 1'b1;
      rx_d               <= 1'b1;
      state              <= IDLE;
      div_cnt            <= '0;
      os_cnt             <= '0;
      bit_cnt            <= '0;
      sh                 <= '0;
      sa                 <= 1'b1;
      sb                 <= 1'b1;
      par                <= 1'b0;
      any_one            <= 1'b0;
      fe_acc             <= 1'b0;
      pe_acc             <= 1'b0;
      dout.rx_data_out   <= '0;
      dout.rx_data_valid <= 1'b0;
      dout.parity_err    <= 1'b0;
      dout.frame_err     <= 1'b0;
      dout.break_det     <= 1'b0;
      dout.overrun_err   <= 1'b0;
    end else begin
      s1   <= rs232_rx;
      s2   <= s1;
      rx_d <= s2;
      // counters idle at zero so the first bit is phase-aligned to the start edge
      div_cnt <= state == IDLE || tick ? '0 : div_cnt + 1'b1;
      if (state == IDLE)
        os_cnt <= '0;
      else if (tick)
        os_cnt <= os_cnt == OW'(OVERSAMPLE - 1) ? '0 : os_cnt + 1'b1;
      if (tick && os_cnt == OW'(OVERSAMPLE / 2 - 1))
        sa <= s2;
      if (tick && os_cnt == OW'(OVERSAMPLE / 2))
        sb <= s2;
      case (state)
        IDLE:
          if (rx_d & ~s2)
            state <= START;
        START:
          if (eval) begin
            state   <= maj ? IDLE : DATA;
            bit_cnt <= '0;
            par     <= 1'b0;
            any_one <= 1'b0;
            fe_acc  <= 1'b0;
            pe_acc  <= 1'b0;
          end
        DATA:
          if (eval) begin
            sh      <= {maj, sh[DATA_BITS-1:1]};
            par     <= par ^ maj;
            any_one <= any_one | maj;
            bit_cnt <= bit_cnt == BW'(DATA_BITS - 1) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == BW'(DATA_BITS - 1))
              state <= PARITY != 0 ? PAR : STOP;
          end
        PAR:
          if (eval) begin
            pe_acc  <= PARITY == 1 ? ~(par ^ maj) : par ^ maj;
            any_one <= any_one | maj;
            state   <= STOP;
          end
        STOP:
          if (eval) begin
            fe_acc  <= fe_acc | ~maj;
            any_one <= any_one | maj;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(STOP_BITS - 1))
              state <= brk ? BRK_WAIT : IDLE;
          end
        BRK_WAIT:
          if (s2)
            state <= IDLE;
        default:
          state <= IDLE;
      endcase
      dout.break_det   <= done & brk;
      dout.overrun_err <= done & pending;
      if (done && !brk && !pending) begin
        dout.rx_data_out   <= sh;
        dout.parity_err    <= pe_acc;
        dout.frame_err     <= fe_acc | ~maj;
        dout.rx_data_valid <= 1'b1;
      end else if (dout.rx_data_valid && dout.rx_data_ready) begin
        dout.rx_data_valid <= 1'b0;
        dout.parity_err    <= 1'b0;
        dout.frame_err     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against a no-parity receiver and an even-parity receiver.
module tb_uart_rx_param;
  localparam int CLK  = 3072000;
  localparam int BAUD = 9600;
  localparam int DIVT = CLK / (BAUD * 16);
  localparam int BIT  = DIVT * 16;
  logic clk = 1'b0, rst_n = 1'b0, ln0 = 1'b1, lnp = 1'b1, rdy0 = 1'b1;
  int cyc = 0, n_chk = 0, n_fail = 0, start_cyc = 0;
  int acc0 = 0, accp = 0, brk0 = 0, ovr0 = 0, rise0 = 0;
  int a, b, o;
  logic [7:0] acc0_data = '0, accp_data = '0;
  logic acc0_pe = 1'b0, acc0_fe = 1'b0, accp_pe = 1'b0, v0_prev = 1'b0;
  uart_rx_param_if #(.DATA_BITS(8)) bus0();
  uart_rx_param_if #(.DATA_BITS(8)) busp();
  assign bus0.rx_data_ready = rdy0;
  assign busp.rx_data_ready = 1'b1;
  uart_rx_param #(.CLK_FREQ(CLK), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut (.clk_in(clk), .rst_n_in(rst_n), .rs232_rx(ln0), .dout(bus0));
  uart_rx_param #(.CLK_FREQ(CLK), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_p (.clk_in(clk), .rst_n_in(rst_n), .rs232_rx(lnp), .dout(busp));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus0.rx_data_valid && !v0_prev) rise0 = cyc;
    v0_prev = bus0.rx_data_valid;
    if (bus0.rx_data_valid && rdy0) begin
      acc0++;
      acc0_data = bus0.rx_data_out;
      acc0_pe   = bus0.parity_err;
      acc0_fe   = bus0.frame_err;
    end
    if (busp.rx_data_valid) begin
      accp++;
      accp_data = busp.rx_data_out;
      accp_pe   = busp.parity_err;
    end
    brk0 += int'(bus0.break_det);
    ovr0 += int'(bus0.overrun_err);
  end
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input bit sel, input logic v);
    if (sel) lnp = v;
    else ln0 = v;
  endtask
  // frame bits LSB first; frame bit g carries a one-tick low pulse over its middle sample
  task automatic send(input bit sel, input int n, input logic [15:0] fb, input int g);
    if (!sel) start_cyc = cyc;
    for (int i = 0; i < n; i++)
      if (i == g) begin
        drv(sel, 1'b1); wait_clk(BIT / 2 + DIVT / 2);
        drv(sel, 1'b0); wait_clk(DIVT);
        drv(sel, 1'b1); wait_clk(BIT / 2 - DIVT - DIVT / 2);
      end else begin
        drv(sel, fb[i]);
        wait_clk(BIT);
      end
  endtask
  initial begin
    wait_clk(4);
    chk("rst_valid", bus0.rx_data_valid, 0);
    chk("rst_data", bus0.rx_data_out, 0);
    chk("rst_busy", bus0.rx_busy, 0);
    chk("rst_brk", bus0.break_det, 0);
    chk("rst_ovr", bus0.overrun_err, 0);
    rst_n = 1'b1;
    wait_clk(BIT);
    a = acc0;
    send(0, 10, {1'b1, 8'hA5, 1'b0}, -1);
    wait_clk(BIT);
    chk("a5_cnt", acc0 - a, 1);
    chk("a5_data", acc0_data, 8'hA5);
    chk("a5_pe", acc0_pe, 0);
    chk("a5_fe", acc0_fe, 0);
    chk("a5_lat", (rise0 - start_cyc >= 19 * BIT / 2) && (rise0 - start_cyc <= 10 * BIT), 1);
    a = acc0;
    ln0 = 1'b0;
    wait_clk(BIT / 4);
    chk("glitch_busy", bus0.rx_busy, 1);
    wait_clk(BIT / 16);
    ln0 = 1'b1;
    wait_clk(BIT / 2);
    chk("glitch_idle", bus0.rx_busy, 0);
    wait_clk(2 * BIT);
    chk("glitch_novalid", acc0 - a, 0);
    a = accp;
    send(1, 11, {1'b1, 1'b1, 8'h03, 1'b0}, -1);
    wait_clk(BIT);
    chk("par1_cnt", accp - a, 1);
    chk("par1_data", accp_data, 8'h03);
    chk("par1_pe", accp_pe, 1);
    send(1, 11, {1'b1, 1'b0, 8'h03, 1'b0}, -1);
    wait_clk(BIT);
    chk("par0_cnt", accp - a, 2);
    chk("par0_pe", accp_pe, 0);
    a = acc0;
    send(0, 10, {1'b0, 8'h55, 1'b0}, -1);
    ln0 = 1'b1;
    wait_clk(2 * BIT);
    chk("fe_cnt", acc0 - a, 1);
    chk("fe_data", acc0_data, 8'h55);
    chk("fe_flag", acc0_fe, 1);
    chk("fe_pe", acc0_pe, 0);
    a = acc0;
    b = brk0;
    ln0 = 1'b0;
    wait_clk(15 * BIT);
    chk("brk_busy", bus0.rx_busy, 1);
    wait_clk(5 * BIT);
    ln0 = 1'b1;
    wait_clk(BIT);
    chk("brk_pulse", brk0 - b, 1);
    chk("brk_idle", bus0.rx_busy, 0);
    chk("brk_novalid", acc0 - a, 0);
    rdy0 = 1'b0;
    o = ovr0;
    send(0, 10, {1'b1, 8'h11, 1'b0}, -1);
    send(0, 10, {1'b1, 8'h22, 1'b0}, -1);
    wait_clk(BIT);
    chk("ovr_valid", bus0.rx_data_valid, 1);
    chk("ovr_data", bus0.rx_data_out, 8'h11);
    chk("ovr_pulse", ovr0 - o, 1);
    a = acc0;
    @(posedge clk);
    #2 rdy0 = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_drop", bus0.rx_data_valid, 0);
    chk("ovr_acc", acc0 - a, 1);
    chk("ovr_accdata", acc0_data, 8'h11);
    wait_clk(BIT);
    a = acc0;
    send(0, 10, {1'b1, 8'hFF, 1'b0}, 4);
    wait_clk(BIT);
    chk("imm_cnt", acc0 - a, 1);
    chk("imm_data", acc0_data, 8'hFF);
    rdy0 = 1'b0;
    send(0, 10, {1'b1, 8'h5A, 1'b0}, -1);
    wait_clk(BIT);
    chk("mid_pending", bus0.rx_data_valid, 1);
    send(0, 3, {1'b1, 8'h3C, 1'b0}, -1);
    chk("mid_busy", bus0.rx_busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_valid", bus0.rx_data_valid, 0);
    chk("mid_data", bus0.rx_data_out, 0);
    chk("mid_idle", bus0.rx_busy, 0);
    ln0 = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    rdy0 = 1'b1;
    wait_clk(2 * BIT);
    a = acc0;
    send(0, 10, {1'b1, 8'h3C, 1'b0}, -1);
    wait_clk(BIT);
    chk("post_cnt", acc0 - a, 1);
    chk("post_data", acc0_data, 8'h3C);
    chk("post_fe", acc0_fe, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver with an internal oversampling baud generator, 3-sample majority voting, configurable data bits, parity and stop bits.
- Detects parity, framing, break and overrun errors.
- Presents each received word on a valid/ready handshake to the downstream consumer (command parser, FIFO).
- Replaces the external-bps_clk receiver in new designs; needs no separate baud-rate module.

Parameters:
- CLK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; even, >= 8.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rs232_rx  input  1  asynchronous serial line, idle high.
- rx_data_out  output  DATA_BITS  received word, LSB = first data bit on the line.
- rx_data_valid  output  1  rx_data_out and flags valid; held until accepted.
- rx_data_ready  input  1  consumer accepts the word when valid & ready in the same cycle.
- parity_err  output  1  parity mismatch for the word on rx_data_out; qualified by valid.
- frame_err  output  1  a stop bit sampled 0 for the word on rx_data_out; qualified by valid.
- break_det  output  1  one-cycle pulse on break detection.
- overrun_err  output  1  one-cycle pulse when a frame completes while the previous word is still unaccepted.
- rx_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - rx_data_out = 0; valid, parity_err, frame_err, break_det, overrun_err, rx_busy = 0.
  - Both synchroniser flops = 1, so no false start is seen after reset.
  - State = IDLE; all counters = 0.
- Input path: 2-FF synchroniser on rs232_rx. All decisions use the synchronised line.
- Baud tick:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated (defaults: DIV = 78, bit = 1248 clocks).
  - Tick = 1-cycle pulse every DIV clocks.
  - Divider and sample counter are cleared on start detection, so sampling is phase-aligned to the falling edge.
- Bit sampling:
  - Within each bit, samples are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, evaluated at tick OVERSAMPLE/2+1.
  - The sample counter wraps at OVERSAMPLE-1.
- FSM (states IDLE, START, DATA, PARITY, STOP, BRK_WAIT):
  - IDLE -> START on a 1->0 transition of the synchronised line.
  - START: majority = 1 -> IDLE (glitch rejected, no flags). Majority = 0 -> DATA.
  - DATA: shift in DATA_BITS bits, LSB first. After the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: sample the parity bit.
    - Odd mode: error if XOR(data, p) = 0.
    - Even mode: error if XOR(data, p) = 1.
  - STOP: check STOP_BITS bits; any 0 sets frame_err. The frame completes at the majority evaluation of the final stop bit.
    - Next state is IDLE, so a new start edge half a bit later is accepted (back-to-back frames).
    - Break case (data all 0, every stop bit 0, parity bit 0 if PARITY != 0) -> BRK_WAIT instead.
  - BRK_WAIT: stay until the synchronised line = 1, then -> IDLE.
- Completion, normal or errored frame (cycle after the final majority evaluation):
  - If !valid, or valid & ready this cycle: load rx_data_out, parity_err and frame_err; valid = 1.
  - Else: overrun_err pulses for 1 cycle. The new word is dropped and the held word and flags are unchanged.
- Break frame: break_det pulses for 1 cycle. It produces no valid and no data load. It still raises overrun_err only if the word from the previous frame is still pending.
- Handshake: valid & ready with no completion in that cycle -> valid = 0 next cycle, and the flags clear with it. rx_data_out holds its last value.
- Asynchronous reset mid-frame: immediate return to reset values; a pending word is discarded.

Test Plan (defaults; 1 bit = 1248 clocks; ready tied high unless stated):
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> exactly 1 valid cycle with rx_data_out = 0xA5, parity_err = 0, frame_err = 0; valid asserts ~9.5 bit times after the start edge.
- Start glitch: line low 400 clocks, then high -> stays IDLE, rx_busy drops ~half a bit after the edge, no valid.
- PARITY = 2: send 0x03 with parity bit 1 -> valid, rx_data_out = 0x03, parity_err = 1. Resend with parity bit 0 -> parity_err = 0.
- Stop bit forced 0 with data 0x55 -> valid, rx_data_out = 0x55, frame_err = 1. Line held 0 for 20 bit times -> break_det pulse once, no valid, busy until the line returns high.
- ready = 0, send 0x11 then 0x22 back-to-back -> rx_data_out stays 0x11 with valid held; overrun_err pulses once at the end of 0x22. Raising ready -> valid drops the next cycle.
- Glitch immunity: a 1-tick (78-clock) low pulse centred on a data-bit mid-sample of 0xFF -> rx_data_out = 0xFF. Reset asserted mid-frame -> all outputs return to 0; the next clean frame 0x3C is received correctly.
